// File: rtl/ws2812_frame_sched_if.sv
// Bus between the frame scheduler, the two picture sources and the WS2812 bit driver.
// The scheduler binds to the master modport; sources and driver bind to the slave modport.
interface ws2812_frame_sched_if #(
  parameter int IDX_W = 6
);
  logic             req_a;
  logic             req_b;
  logic [23:0]      data_a;
  logic [23:0]      data_b;
  logic             cfg_start;
  logic             ws2812_start;
  logic [IDX_W-1:0] cfg_num;
  logic [23:0]      cfg_data;
  logic [1:0]       grant;
  logic             frame_done;
  logic             wdog_err;

  modport master (
    input  req_a, req_b, data_a, data_b, cfg_start,
    output ws2812_start, cfg_num, cfg_data, grant, frame_done, wdog_err
  );

  modport slave (
    output req_a, req_b, data_a, data_b, cfg_start,
    input  ws2812_start, cfg_num, cfg_data, grant, frame_done, wdog_err
  );
endinterface

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler/arbiter for the 8x8 WS2812 matrix: grants one of two sources per frame, steps pixels.
// Optional macro WS2812_DIM_EN: divides every colour channel by 8 before it reaches the driver.
module ws2812_frame_sched #(
  parameter int PIXELS      = 64,
  parameter int IDX_W       = 6,
  parameter int PWRUP_CYC   = 1_000_000,
  parameter int REFRESH_CYC = 1_000_000,
  parameter int WDOG_CYC    = 8192
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  ws2812_frame_sched_if.master  bus
);

  localparam int PW_W = $clog2(PWRUP_CYC);
  localparam int RF_W = $clog2(REFRESH_CYC);
  localparam int WD_W = $clog2(WDOG_CYC);

  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PWRUP_CYC - 1);
  localparam logic [RF_W-1:0]  RF_LAST  = RF_W'(REFRESH_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYC - 1);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(PIXELS - 1);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_IDLE  = 3'd1,
    S_ARB   = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PW_W-1:0]  pw_cnt;
  logic [RF_W-1:0]  rf_cnt;
  logic [WD_W-1:0]  wd_cnt;

  // Requests as seen on the edge that left IDLE; the arbiter decides on these.
  logic             req_a_lat;
  logic             req_b_lat;

  logic             last_b;
  logic             last_b_nxt;
  logic [1:0]       grant_q;
  logic [1:0]       grant_nxt;
  logic [IDX_W-1:0] num_q;
  logic [IDX_W-1:0] num_nxt;
  logic             start_q;
  logic             start_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             wdog_q;
  logic             wdog_nxt;

  logic             req_any;
  logic             refresh_due;
  logic             pix_last;
  logic             wd_expire;
  logic [23:0]      sel_data;

  assign req_any     = bus.req_a | bus.req_b;
  assign refresh_due = (rf_cnt == RF_LAST);
  assign pix_last    = (num_q == PIX_LAST);
  assign wd_expire   = (wd_cnt == WD_LAST);

  // State register and the per-state cycle counters
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_PWRUP;
      pw_cnt    <= '0;
      rf_cnt    <= '0;
      wd_cnt    <= '0;
      req_a_lat <= 1'b0;
      req_b_lat <= 1'b0;
    end else begin
      state  <= state_nxt;
      pw_cnt <= (state == S_PWRUP && state_nxt == S_PWRUP) ? pw_cnt + 1'b1 : '0;
      rf_cnt <= (state == S_IDLE  && state_nxt == S_IDLE)  ? rf_cnt + 1'b1 : '0;
      wd_cnt <= (state == S_RUN && state_nxt == S_RUN && !bus.cfg_start) ? wd_cnt + 1'b1 : '0;
      if (state == S_IDLE) begin
        req_a_lat <= bus.req_a;
        req_b_lat <= bus.req_b;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_PWRUP: if (pw_cnt == PW_LAST)          state_nxt = S_IDLE;
      S_IDLE:  if (req_any || refresh_due)     state_nxt = S_ARB;
      S_ARB:                                   state_nxt = S_START;
      S_START:                                 state_nxt = S_RUN;
      S_RUN: begin
        if (bus.cfg_start) begin
          if (pix_last) state_nxt = S_IDLE;
        end else if (wd_expire) begin
          state_nxt = S_IDLE;
        end
      end
      default:                                 state_nxt = S_PWRUP;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    grant_nxt  = grant_q;
    num_nxt    = num_q;
    last_b_nxt = last_b;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    wdog_nxt   = 1'b0;
    unique case (state)
      S_ARB: begin
        if (req_a_lat && req_b_lat) begin
          grant_nxt = last_b ? GNT_A : GNT_B;
        end else if (req_a_lat) begin
          grant_nxt = GNT_A;
        end else if (req_b_lat) begin
          grant_nxt = GNT_B;
        end else begin
          grant_nxt = last_b ? GNT_B : GNT_A;
        end
        last_b_nxt = grant_nxt[1];
      end
      S_START: begin
        start_nxt = 1'b1;
        num_nxt   = '0;
      end
      S_RUN: begin
        // A consumed pixel always wins over a watchdog expiry in the same cycle.
        if (bus.cfg_start) begin
          if (pix_last) begin
            num_nxt   = '0;
            grant_nxt = GNT_NONE;
            done_nxt  = 1'b1;
          end else begin
            num_nxt = num_q + 1'b1;
          end
        end else if (wd_expire) begin
          num_nxt   = '0;
          grant_nxt = GNT_NONE;
          wdog_nxt  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_q <= GNT_NONE;
      num_q   <= '0;
      last_b  <= 1'b1;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      wdog_q  <= 1'b0;
    end else begin
      grant_q <= grant_nxt;
      num_q   <= num_nxt;
      last_b  <= last_b_nxt;
      start_q <= start_nxt;
      done_q  <= done_nxt;
      wdog_q  <= wdog_nxt;
    end
  end

`ifdef WS2812_DIM_EN
  function automatic logic [23:0] dim_color(input logic [23:0] c);
    return {3'b000, c[23:19], 3'b000, c[15:11], 3'b000, c[7:3]};
  endfunction
`endif

  always_comb begin
    unique case (grant_q)
      GNT_A:   sel_data = bus.data_a;
      GNT_B:   sel_data = bus.data_b;
      default: sel_data = 24'h0;
    endcase
  end

`ifdef WS2812_DIM_EN
  assign bus.cfg_data = dim_color(sel_data);
`else
  assign bus.cfg_data = sel_data;
`endif

  assign bus.ws2812_start = start_q;
  assign bus.cfg_num      = num_q;
  assign bus.grant        = grant_q;
  assign bus.frame_done   = done_q;
  assign bus.wdog_err     = wdog_q;

endmodule
